uart_tx_buffered: RTL and testbench
===================================

# uart_tx_buffered

Buffered UART transmitter: accepts bytes over a valid/ready handshake into a small FIFO and serialises each one onto a single TX line as 8N1 frames at 16x oversampled baud. It is the sending end for the existing UART receiver path in `Modulo_Uart_Top`: its `o_tx` drives a receiver's `i_data` directly. It also has its own frame-aligned tick generator. It sits between the ALU/interface logic that produces results and the TX pin.

## Interface
- `DBIT`, 8: data bits per frame.
- `SB_TICK`, 16: stop-bit length in ticks (16 = 1 stop bit, 32 = 2 stop bits).
- `DIV`, 163: clocks per oversampling tick. Must be ≥ 2.
- `FIFO_AW`, 2: FIFO address width; depth = 2^FIFO_AW = 4.
- `i_clock`  in  1: single clock; all logic on its rising edge.
- `i_reset`  in  1: reset; synchronous, active-low.
- `i_data`  in  DBIT: byte to send.
- `i_valid`  in  1: `i_data` is valid.
- `o_ready`  out  1: FIFO can accept; a push happens when `i_valid && o_ready`.
- `o_tx`  out  1: serial line, idle high, registered.
- `o_tx_done`  out  1: one-cycle pulse at end of each frame's stop bit.
- `o_busy`  out  1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `o_tx` = 1; tick counter held at 0. If the FIFO is non-empty, pop the head into shift register `b`, clear `s` and `n`, and go to START.
  - START: `o_tx` = 0 for 16 ticks, then go to DATA.
  - DATA: `o_tx` = `b[0]`. After 16 ticks, shift `b` right by one and increment `n`. After bit `DBIT-1`, go to STOP. Bits go out LSB first.
  - STOP: `o_tx` = 1 for `SB_TICK` ticks. On the final tick, pulse `o_tx_done` and return to IDLE.
- Tick generator: counter runs 0..DIV-1 only outside IDLE, restarts at 0 on entry to START, and asserts tick when count = DIV-1. Frame length is therefore exact and independent of arrival time.
- FIFO: synchronous, depth 2^FIFO_AW. `o_ready` = !full while `i_reset` is high. A push is never dropped, and data is never accepted when full.
- Push and pop in the same cycle: both take effect; occupancy is unchanged.
- Push while empty and IDLE: the byte is visible to the FSM the next cycle.
- Reset mid-frame: at the next edge `o_tx` = 1, FSM is in IDLE, and the FIFO is flushed. No `o_tx_done` is produced for the aborted frame.

## Timing
- Reset values while `i_reset` = 0: `o_tx` = 1, `o_ready` = 0, `o_tx_done` = 0, `o_busy` = 0, FIFO empty, all counters 0.
- Latency: a push accepted at edge N into an empty FIFO with FSM in IDLE gives `o_tx` = 0 and `o_busy` = 1 after edge N+2.
- Bit cell = 16·DIV clocks (2608 at defaults). Stop = SB_TICK·DIV clocks.
- Frame = (1+DBIT)·16·DIV + SB_TICK·DIV clocks (26080 at defaults).
- `o_tx_done` is high for exactly the last cycle of STOP.
- Back-to-back frames: exactly one IDLE cycle with `o_tx` = 1 separates consecutive frames.
- `o_ready` reflects FIFO state after the current edge. It deasserts in the cycle after the push that fills the FIFO.

## Structure
- Shared package `uart_pkg`:
  - state encoding typedef (IDLE/START/DATA/STOP);
  - default constants `UART_DBIT` = 8, `UART_SB_TICK` = 16, `UART_DIV` = 163, `UART_OVERSAMPLE` = 16.
- This block uses `uart_pkg`. The receiver is to be migrated onto it.
- One sub-module: `uart_tx_fifo`, a parameterised synchronous FIFO with push/pop/full/empty. The FSM, tick counter and shift register live in `uart_tx_buffered`.

## Test plan
- Single byte, defaults: push 8'h1B once.
  - `o_tx` low for 2608 clocks, then 1,1,0,1,1,0,0,0 at 2608 clocks each, then high for 2608.
  - `o_tx_done` pulses once, 26080 clocks after start-bit fall.
- Loopback: `o_tx` into an existing `Modulo_Uart_Top` receiver instance (DIV = 163). Send 8'h1B, 8'h00, 8'hFF, 8'hA5; the receiver output matches each in order.
- Back-pressure: hold `i_valid` with bytes 8'h01..8'h06.
  - FIFO fills to 4 and `o_ready` drops; no byte is lost or duplicated.
  - Exactly 6 frames come out, each separated by exactly one idle cycle.
- Simultaneous push/pop: FIFO holding 1 byte with FSM in IDLE, push a second byte in the same cycle as the pop. Occupancy stays 1 and both bytes are sent in order.
- Reset mid-frame: assert `i_reset` low during the DATA bit 3 cell with 2 bytes queued.
  - `o_tx` = 1 and `o_ready` = 0 after the next edge; no `o_tx_done`.
  - After release, the FIFO is empty and the line stays idle.
- Stop length: `SB_TICK` = 32, `DIV` = 4, send 8'h80. Stop bit lasts 128 clocks; the frame is 704 clocks.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter/receiver state encoding and default
// frame/baud constants.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int unsigned UART_DBIT       = 8;
  localparam int unsigned UART_SB_TICK    = 16;
  localparam int unsigned UART_DIV        = 163;
  localparam int unsigned UART_OVERSAMPLE = 16;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO for the buffered UART transmitter.
//   i_clock  : clock, rising edge
//   i_reset  : synchronous active-low reset, flushes the FIFO
//   i_push   : write i_data (ignored when full)
//   i_pop    : drop head entry (ignored when empty)
//   o_data   : current head entry
//   o_full   : 2^AW entries held
//   o_empty  : no entries held
module uart_tx_fifo #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 2
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic [DW-1:0] o_data,
  output logic          o_full,
  output logic          o_empty
);

  localparam int unsigned DEPTH      = 1 << AW;
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign o_full  = (count == FULL_COUNT);
  assign o_empty = (count == '0);
  assign do_push = i_push && !o_full;
  assign do_pop  = i_pop && !o_empty;
  assign o_data  = mem[rd_ptr];

  always_ff @(posedge i_clock) begin
    if (do_push) mem[wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter with 16x oversampled, frame-aligned ticks.
//   i_clock   : clock, rising edge
//   i_reset   : synchronous active-low reset
//   i_data    : byte to send
//   i_valid   : i_data valid; pushed when i_valid && o_ready
//   o_ready   : FIFO can accept (low while in reset)
//   o_tx      : serial line, idle high, registered
//   o_tx_done : one-cycle pulse on the last cycle of each stop bit on o_tx
//   o_busy    : FSM not in IDLE
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int unsigned DBIT    = UART_DBIT,
  parameter int unsigned SB_TICK = UART_SB_TICK,
  parameter int unsigned DIV     = UART_DIV,
  parameter int unsigned FIFO_AW = 2
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic [DBIT-1:0] i_data,
  input  logic            i_valid,
  output logic            o_ready,
  output logic            o_tx,
  output logic            o_tx_done,
  output logic            o_busy
);

  localparam int unsigned S_MAX = (SB_TICK > UART_OVERSAMPLE) ? SB_TICK : UART_OVERSAMPLE;
  localparam int unsigned S_W   = $clog2(S_MAX);
  localparam int unsigned N_W   = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam int unsigned D_W   = $clog2(DIV);

  localparam logic [S_W-1:0] S_CELL_LAST = S_W'(UART_OVERSAMPLE - 1);
  localparam logic [S_W-1:0] S_STOP_LAST = S_W'(SB_TICK - 1);
  localparam logic [N_W-1:0] N_LAST      = N_W'(DBIT - 1);
  localparam logic [D_W-1:0] D_LAST      = D_W'(DIV - 1);

  uart_state_e     state_q, state_d;
  logic [D_W-1:0]  div_q;
  logic            tick;
  logic [S_W-1:0]  s_q, s_d;
  logic [N_W-1:0]  n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            tx_d;
  logic            done_d;
  logic            push;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [DBIT-1:0] fifo_data;

  assign o_ready = i_reset && !fifo_full;
  assign push    = i_valid && o_ready;
  assign o_busy  = (state_q != IDLE);
  assign tick    = (state_q != IDLE) && (div_q == D_LAST);

  uart_tx_fifo #(
    .DW(DBIT),
    .AW(FIFO_AW)
  ) u_fifo (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_push  (push),
    .i_data  (i_data),
    .i_pop   (pop),
    .o_data  (fifo_data),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  // Divider is parked at 0 in IDLE, so every frame starts on a fresh tick period.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q   <= IDLE;
      div_q     <= '0;
      s_q       <= '0;
      n_q       <= '0;
      b_q       <= '0;
      o_tx      <= 1'b1;
      o_tx_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      n_q       <= n_d;
      b_q       <= b_d;
      o_tx      <= tx_d;
      o_tx_done <= done_d;
      if (state_q == IDLE || div_q == D_LAST) div_q <= '0;
      else                                    div_q <= div_q + D_W'(1);
    end
  end

  // Line level and done pulse are computed from the current state and
  // registered, so o_tx_done lines up with the last stop cycle on o_tx.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    pop     = 1'b0;
    tx_d    = 1'b1;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          b_d     = fifo_data;
          s_d     = '0;
          n_d     = '0;
          state_d = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (tick) begin
          if (s_q == S_CELL_LAST) begin
            s_d     = '0;
            state_d = DATA;
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      DATA: begin
        tx_d = b_q[0];
        if (tick) begin
          if (s_q == S_CELL_LAST) begin
            s_d = '0;
            b_d = b_q >> 1;
            if (n_q == N_LAST) state_d = STOP;
            else               n_d     = n_q + N_W'(1);
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (s_q == S_STOP_LAST) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: main instance at DIV=4 (64-clock bit cell),
// second instance with SB_TICK=32, DIV=4 for stop length.
module tb_uart_tx_buffered;

  localparam int unsigned DIV_T    = 4;
  localparam int unsigned CELL     = 16 * DIV_T;
  localparam int unsigned STOP_CLK = 16 * DIV_T;
  localparam int unsigned FRAME    = 9 * CELL + STOP_CLK;

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;  // bit k = line level in cell k (start, d0..d7, stop)
  } vec_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din   = '0;
  logic       valid = 1'b0;
  logic       ready, tx, done, busy;
  logic [7:0] din2   = '0;
  logic       valid2 = 1'b0;
  logic       ready2, tx2, done2, busy2;

  int unsigned vectors = 0, miscompares = 0;
  int unsigned cyc = 0, frames = 0, gap_one = 0;
  logic [9:0]  exp_q[$];

  uart_tx_buffered #(.DBIT(8), .SB_TICK(16), .DIV(DIV_T), .FIFO_AW(2)) dut (
    .i_clock(clk), .i_reset(rst_n), .i_data(din), .i_valid(valid),
    .o_ready(ready), .o_tx(tx), .o_tx_done(done), .o_busy(busy));

  uart_tx_buffered #(.DBIT(8), .SB_TICK(32), .DIV(DIV_T), .FIFO_AW(2)) dut2 (
    .i_clock(clk), .i_reset(rst_n), .i_data(din2), .i_valid(valid2),
    .o_ready(ready2), .o_tx(tx2), .o_tx_done(done2), .o_busy(busy2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic [9:0] line);
    int unsigned w = 0;
    @(negedge clk);
    din = d; valid = 1'b1;
    #1;
    while (ready !== 1'b1) begin
      if (w > 4 * FRAME) begin
        check("accept timeout", 0, 1);
        valid = 1'b0;
        return;
      end
      w++;
      @(negedge clk); #1;
    end
    exp_q.push_back(line);
    @(posedge clk);
  endtask

  task automatic wait_frames(input int unsigned target);
    int unsigned w = 0;
    while (frames < target) begin
      if (w > 8 * FRAME) begin
        check("frame wait timeout", frames, target);
        return;
      end
      w++;
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
  endtask

  // Frame monitor: on each start-bit fall, pop the expected line pattern and
  // check every cycle of the frame plus the done pulse placement.
  initial begin : monitor
    logic        prev;
    logic [9:0]  want, got;
    logic        exp_bit;
    int unsigned t0, last_end, bad, dcnt;
    bit          aborted, dlast, have;
    prev = 1'b1; last_end = 0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin prev = 1'b1; continue; end
      if (!(prev === 1'b1 && tx === 1'b0)) begin prev = tx; continue; end
      t0 = cyc;
      if (frames > 0 && t0 - last_end - 1 == 1) gap_one++;
      have = (exp_q.size() != 0);
      want = have ? exp_q.pop_front() : 10'h3FF;
      got = '0; bad = 0; dcnt = 0; dlast = 0; aborted = 0;
      for (int unsigned k = 0; k < FRAME; k++) begin
        if (k != 0) @(negedge clk);
        if (rst_n !== 1'b1) begin aborted = 1; break; end
        exp_bit = (k / CELL < 9) ? want[k / CELL] : want[9];
        if (tx !== exp_bit) bad++;
        if (k % CELL == CELL / 2 && k / CELL < 10) got[k / CELL] = tx;
        if (done === 1'b1) begin
          dcnt++;
          if (k == FRAME - 1) dlast = 1;
        end
      end
      prev = aborted ? 1'b1 : tx;
      if (!aborted) begin
        last_end = t0 + FRAME - 1;
        check("frame expected", have, 1);
        if (have) begin
          check("frame bits", got, want);
          check("frame cycles off pattern", bad, 0);
          check("done pulse count", dcnt, 1);
          check("done on last stop cycle", dlast, 1);
        end
        frames++;
      end
    end
  end

  initial begin : watchdog
    repeat (40000) @(posedge clk);
    miscompares++;
    $display("FAIL watchdog: got %0d cycles without completion, expected end sooner", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    vec_t        tab[4];
    int unsigned f0, g0, w, lows, busys, dsum, lowc, stopc, dcnt2, dk;
    bit          past;

    tab[0] = '{8'h1B, 10'h236};
    tab[1] = '{8'h00, 10'h200};
    tab[2] = '{8'hFF, 10'h3FE};
    tab[3] = '{8'hA5, 10'h34A};

    // Reset values
    repeat (3) @(negedge clk);
    check("reset tx", tx, 1);
    check("reset ready", ready, 0);
    check("reset done", done, 0);
    check("reset busy", busy, 0);
    check("reset fifo count", dut.u_fifo.count, 0);
    check("reset dut2 tx", tx2, 1);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready after reset", ready, 1);

    // Table: single bytes, with push-to-start-bit latency
    for (int i = 0; i < 4; i++) begin
      f0 = frames;
      send(tab[i].data, tab[i].line);
      @(negedge clk); valid = 1'b0;
      check("latency busy after N", busy, 0);
      @(negedge clk);
      check("latency busy after N+1", busy, 1);
      check("latency tx after N+1", tx, 1);
      @(negedge clk);
      check("latency tx after N+2", tx, 0);
      wait_frames(f0 + 1);
    end

    // Back-pressure: bytes 1..6 with valid held
    f0 = frames; g0 = gap_one;
    for (int i = 1; i <= 5; i++) send(8'(i), {1'b1, 8'(i), 1'b0});
    @(negedge clk);
    check("bp ready low when full", ready, 0);
    check("bp fifo full count", dut.u_fifo.count, 4);
    send(8'h06, {1'b1, 8'h06, 1'b0});
    @(negedge clk); valid = 1'b0;
    wait_frames(f0 + 6);
    check("bp frame count", frames - f0, 6);
    check("bp single idle gaps", gap_one - g0, 5);
    check("bp scoreboard drained", exp_q.size(), 0);

    // Push in the same cycle as the pop of the head
    f0 = frames; g0 = gap_one;
    send(8'h96, {1'b1, 8'h96, 1'b0});
    send(8'h69, {1'b1, 8'h69, 1'b0});
    @(negedge clk); valid = 1'b0;
    check("simul occupancy", dut.u_fifo.count, 1);
    check("simul busy", busy, 1);
    wait_frames(f0 + 2);
    check("simul gap", gap_one - g0, 1);

    // Two stop bits: SB_TICK=32, DIV=4, byte 8'h80
    @(negedge clk); din2 = 8'h80; valid2 = 1'b1;
    #1; check("dut2 ready", ready2, 1);
    @(negedge clk); valid2 = 1'b0;
    w = 0;
    while (tx2 !== 1'b0 && w < 16) begin @(negedge clk); w++; end
    check("dut2 start seen", tx2, 0);
    lowc = 0; stopc = 0; dcnt2 = 0; dk = 0; past = 0;
    for (int unsigned k = 0; k < 800; k++) begin
      if (k != 0) @(negedge clk);
      if (tx2 === 1'b0) lowc++;
      if (k >= 9 * CELL && !past && tx2 === 1'b1) stopc++;
      if (done2 === 1'b1) begin dcnt2++; dk = k; past = 1; end
    end
    check("dut2 low cycles (start+7 zeros)", lowc, 8 * CELL);
    check("dut2 stop cycles", stopc, 128);
    check("dut2 frame clocks", dk + 1, 704);
    check("dut2 done count", dcnt2, 1);

    // Reset during data bit 3 with two bytes queued
    f0 = frames;
    send(8'h3C, {1'b1, 8'h3C, 1'b0});
    send(8'hC3, {1'b1, 8'hC3, 1'b0});
    send(8'h5A, {1'b1, 8'h5A, 1'b0});
    @(negedge clk); valid = 1'b0;
    w = 0;
    while (tx !== 1'b0 && w < 16) begin @(negedge clk); w++; end
    check("rst test start seen", tx, 0);
    repeat (4 * CELL + CELL / 2) @(negedge clk);
    check("rst test busy before", busy, 1);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("rst mid tx", tx, 1);
    check("rst mid ready", ready, 0);
    check("rst mid busy", busy, 0);
    check("rst mid done", done, 0);
    dsum = 0;
    repeat (3) begin @(negedge clk); if (done === 1'b1) dsum++; end
    rst_n = 1'b1;
    lows = 0; busys = 0;
    for (int unsigned i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
      if (busy !== 1'b0) busys++;
      if (done === 1'b1) dsum++;
    end
    check("rst idle line low cycles", lows, 0);
    check("rst idle busy cycles", busys, 0);
    check("rst no done pulse", dsum, 0);
    check("rst no frames completed", frames - f0, 0);
    check("rst fifo flushed", dut.u_fifo.count, 0);
    check("rst ready after release", ready, 1);

    check("scoreboard empty at end", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
